// File: rtl/seg7_bcd_axil_writer.sv
// ---------------------------------------------------------------------------
// seg7_bcd_axil_writer
//
// Upstream feeder for the AXI4-Lite 7-segment display slave. A request is a
// binary value plus a dot mask. The value is converted to packed BCD by a
// sequential double-dabble engine, one input bit per cycle. The result is then
// written to the slave's digit register at BASE_ADDR. When WRITE_DOTS is set,
// the dot mask is then written to BASE_ADDR+4.
//
// Ports
//   clk, rstn         clock; synchronous active-low reset
//   in_valid/ready    request handshake. in_ready is high only in IDLE.
//                     A transfer occurs on a rising edge where both are high.
//   in_value, in_dots value to show; dot bit i belongs to digit i
//   done              one-cycle pulse after the final write response
//   resp_err/err_clr  sticky error on BRESP != OKAY. An error being set in
//                     the same cycle as err_clr wins over the clear.
//   overflow          last accepted value did not fit in DIGITS digits
//   m_axi_aw*/w*/b*   AXI4-Lite write channels (master side)
//
// Every AXI channel uses the usual valid/ready rule. A beat transfers on the
// rising edge where valid and ready are both high. Once valid is raised, the
// payload is held stable and valid stays high until that edge.
// ---------------------------------------------------------------------------
module seg7_bcd_axil_writer #(
    parameter int          BIN_W      = 10,
    parameter int          DIGITS     = 3,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          WRITE_DOTS = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BIN_W-1:0]  in_value,
    input  logic [DIGITS-1:0] in_dots,
    output logic              done,
    output logic              resp_err,
    input  logic              err_clr,
    output logic              overflow,
    output logic [31:0]       m_axi_awaddr,
    output logic [2:0]        m_axi_awprot,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [31:0]       m_axi_wdata,
    output logic [3:0]        m_axi_wstrb,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready
);

    localparam int BCD_W = DIGITS * 4;
    localparam int CNT_W = $clog2(BIN_W + 1);

    function automatic logic [63:0] calc_max();
        logic [63:0] v;
        v = 64'd1;
        for (int i = 0; i < DIGITS; i++) v = v * 64'd10;
        return v - 64'd1;
    endfunction

    localparam logic [63:0] MAX_VAL = calc_max();

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONV,
        S_WR_DIG,
        S_B_DIG,
        S_WR_DOT,
        S_B_DOT
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [BIN_W-1:0]    bin_q;
    logic [BCD_W-1:0]    bcd_q;
    logic [DIGITS-1:0]   dots_q;
    logic                aw_done;
    logic                w_done;

    logic [BCD_W-1:0]    bcd_adj;
    logic [BCD_W-1:0]    bcd_next;
    logic                aw_fire;
    logic                w_fire;
    logic                b_fire;
    logic                aw_ok;
    logic                w_ok;

    assign in_ready     = (state == S_IDLE);
    assign m_axi_awprot = 3'b000;
    assign m_axi_wstrb  = 4'hF;

    assign aw_fire = m_axi_awvalid & m_axi_awready;
    assign w_fire  = m_axi_wvalid & m_axi_wready;
    assign b_fire  = m_axi_bready & m_axi_bvalid;
    // A channel counts as done if it completed earlier or completes now.
    assign aw_ok   = aw_done | aw_fire;
    assign w_ok    = w_done | w_fire;

    // One double-dabble step: add 3 to every nibble >= 5, then shift in the
    // next binary MSB. Bits leaving the top of the accumulator are dropped.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        bcd_next = {bcd_adj[BCD_W-2:0], bin_q[BIN_W-1]};
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state         <= S_IDLE;
            cnt           <= '0;
            bin_q         <= '0;
            bcd_q         <= '0;
            dots_q        <= '0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            done          <= 1'b0;
            resp_err      <= 1'b0;
            overflow      <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_wdata   <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
        end else begin
            done <= 1'b0;
            // A response error assigned later in this block overrides the clear.
            if (err_clr) resp_err <= 1'b0;
            // Each valid drops on its own handshake, independently of the other.
            if (aw_fire) m_axi_awvalid <= 1'b0;
            if (w_fire)  m_axi_wvalid  <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        bin_q    <= in_value;
                        dots_q   <= in_dots;
                        bcd_q    <= '0;
                        cnt      <= '0;
                        overflow <= (64'(in_value) > MAX_VAL);
                        state    <= S_CONV;
                    end
                end

                S_CONV: begin
                    bcd_q <= bcd_next;
                    bin_q <= bin_q << 1;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CNT_W'(BIN_W - 1)) begin
                        // The last step's result goes straight into wdata.
                        m_axi_awaddr  <= BASE_ADDR;
                        m_axi_wdata   <= overflow ? 32'({DIGITS{4'hE}}) : 32'(bcd_next);
                        m_axi_awvalid <= 1'b1;
                        m_axi_wvalid  <= 1'b1;
                        aw_done       <= 1'b0;
                        w_done        <= 1'b0;
                        state         <= S_WR_DIG;
                    end
                end

                S_WR_DIG, S_WR_DOT: begin
                    aw_done <= aw_ok;
                    w_done  <= w_ok;
                    if (aw_ok && w_ok) begin
                        m_axi_bready <= 1'b1;
                        state        <= (state == S_WR_DIG) ? S_B_DIG : S_B_DOT;
                    end
                end

                S_B_DIG: begin
                    if (b_fire) begin
                        m_axi_bready <= 1'b0;
                        if (m_axi_bresp != 2'b00) resp_err <= 1'b1;
                        if (WRITE_DOTS != 0) begin
                            m_axi_awaddr  <= BASE_ADDR + 32'd4;
                            m_axi_wdata   <= 32'(dots_q);
                            m_axi_awvalid <= 1'b1;
                            m_axi_wvalid  <= 1'b1;
                            aw_done       <= 1'b0;
                            w_done        <= 1'b0;
                            state         <= S_WR_DOT;
                        end else begin
                            done  <= 1'b1;
                            state <= S_IDLE;
                        end
                    end
                end

                S_B_DOT: begin
                    if (b_fire) begin
                        m_axi_bready <= 1'b0;
                        if (m_axi_bresp != 2'b00) resp_err <= 1'b1;
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_bcd_axil_writer.sv
// ---------------------------------------------------------------------------
// tb_seg7_bcd_axil_writer
//
// Directed bench for seg7_bcd_axil_writer. It uses default parameters:
// BIN_W=10, DIGITS=3, BASE_ADDR=0 and WRITE_DOTS=1.
//
// A slave model drives the AXI responses. It can stall AWREADY or WREADY,
// queue BRESP codes, and hold back BVALID. Each request pushes its
// hand-computed writes onto exp_q. A monitor pops exp_q whenever it sees a
// completed address+data pair, and also checks that payloads stay stable
// while the slave stalls.
// ---------------------------------------------------------------------------
module tb_seg7_bcd_axil_writer;

    localparam int          BIN_W  = 10;
    localparam int          DIGITS = 3;
    localparam logic [31:0] BASE   = 32'h0000_0000;

    logic              clk;
    logic              rstn;
    logic              in_valid;
    logic              in_ready;
    logic [BIN_W-1:0]  in_value;
    logic [DIGITS-1:0] in_dots;
    logic              done;
    logic              resp_err;
    logic              err_clr;
    logic              overflow;
    logic [31:0]       awaddr;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    seg7_bcd_axil_writer #(
        .BIN_W(BIN_W), .DIGITS(DIGITS), .BASE_ADDR(BASE), .WRITE_DOTS(1)
    ) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_value(in_value), .in_dots(in_dots),
        .done(done), .resp_err(resp_err), .err_clr(err_clr), .overflow(overflow),
        .m_axi_awaddr(awaddr), .m_axi_awprot(awprot),
        .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int vectors     = 0;
    int miscompares = 0;
    int done_cnt    = 0;
    logic [63:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- slave model ----------------
    int       aw_stall = 0;
    int       w_stall  = 0;
    bit       b_block  = 0;
    logic [1:0] bresp_q[$];

    initial begin
        int  aw_cnt, w_cnt;
        bit  aw_seen, w_seen, s_awv, s_wv, s_br;
        bit  f_aw, f_w, f_b;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        aw_cnt = 0; w_cnt = 0; aw_seen = 0; w_seen = 0;
        s_awv = 0; s_wv = 0; s_br = 0;
        forever begin
            @(posedge clk); #1;
            if (!rstn) begin
                awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
                aw_cnt = 0; w_cnt = 0; aw_seen = 0; w_seen = 0;
                s_awv = 0; s_wv = 0; s_br = 0;
            end else begin
                // Handshakes that fired on the edge just passed.
                f_aw = s_awv && awready;
                f_w  = s_wv && wready;
                f_b  = bvalid && s_br;
                if (f_aw) aw_seen = 1;
                if (f_w)  w_seen  = 1;
                if (f_b) begin bvalid = 1'b0; bresp = 2'b00; end
                if (aw_seen && w_seen && !bvalid && !b_block) begin
                    bvalid = 1'b1;
                    bresp  = (bresp_q.size() > 0) ? bresp_q.pop_front() : 2'b00;
                    aw_seen = 0; w_seen = 0;
                end
                awready = awvalid && (aw_cnt >= aw_stall);
                if (awvalid && !awready) aw_cnt++;
                if (!awvalid) aw_cnt = 0;
                wready = wvalid && (w_cnt >= w_stall);
                if (wvalid && !wready) w_cnt++;
                if (!wvalid) w_cnt = 0;
                s_awv = awvalid; s_wv = wvalid; s_br = bready;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        bit          got_a, got_w, p_rst, p_awv, p_awr, p_wv, p_wr;
        logic [31:0] cap_a, cap_w, p_awaddr, p_wdata;
        logic [63:0] e;
        got_a = 0; got_w = 0; p_rst = 0;
        p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0;
        cap_a = '0; cap_w = '0; p_awaddr = '0; p_wdata = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                got_a = 0; got_w = 0;
            end else begin
                if (p_rst && p_awv && !p_awr) begin
                    vectors++;
                    if (!awvalid || awaddr !== p_awaddr) begin
                        miscompares++;
                        $display("FAIL aw_stable: got valid=%b addr=%h expected valid=1 addr=%h", awvalid, awaddr, p_awaddr);
                    end
                end
                if (p_rst && p_wv && !p_wr) begin
                    vectors++;
                    if (!wvalid || wdata !== p_wdata) begin
                        miscompares++;
                        $display("FAIL w_stable: got valid=%b data=%h expected valid=1 data=%h", wvalid, wdata, p_wdata);
                    end
                end
                if (awvalid && awready) begin got_a = 1; cap_a = awaddr; end
                if (wvalid && wready)   begin got_w = 1; cap_w = wdata;  end
                if (got_a && got_w) begin
                    got_a = 0; got_w = 0;
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL write_unexpected: got addr=%h data=%h expected no write", cap_a, cap_w);
                    end else begin
                        e = exp_q.pop_front();
                        if ({cap_a, cap_w} !== e) begin
                            miscompares++;
                            $display("FAIL write: got addr=%h data=%h expected addr=%h data=%h",
                                     cap_a, cap_w, e[63:32], e[31:0]);
                        end
                    end
                end
                if (done) done_cnt++;
            end
            p_rst = rstn; p_awv = awvalid; p_awr = awready; p_wv = wvalid; p_wr = wready;
            p_awaddr = awaddr; p_wdata = wdata;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input int v, input logic [DIGITS-1:0] d);
        @(negedge clk);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_value = BIN_W'(v);
        in_dots  = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
        // Changes while busy must be ignored.
        in_value = '1;
        in_dots  = '0;
    endtask

    task automatic run_req(input int v, input logic [DIGITS-1:0] d, input logic [11:0] exp_bcd,
                           input logic exp_ovf, input bit chk_lat,
                           output int aw_hi, output int w_hi);
        int  d0, lat;
        bit  got;
        exp_q.push_back({BASE, 32'(exp_bcd)});
        exp_q.push_back({BASE + 32'd4, 32'(d)});
        d0 = done_cnt; lat = 0; got = 0; aw_hi = 0; w_hi = 0;
        issue(v, d);
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            if (awvalid) begin
                if (lat == 0) lat = c;
                aw_hi++;
            end
            if (wvalid) w_hi++;
            if (done) begin got = 1; break; end
        end
        if (!got) check("done_timeout", 32'd0, 32'd1);
        else      check("in_ready_at_done", 32'(in_ready), 32'd1);
        if (chk_lat) check("aw_latency", 32'(lat), 32'(BIN_W + 1));
        @(negedge clk);
        check("done_pulses", 32'(done_cnt - d0), 32'd1);
        check("done_one_cycle", 32'(done), 32'd0);
        check("overflow", 32'(overflow), 32'(exp_ovf));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int aw_hi, w_hi;
        bit hit;
        rstn = 1'b0; in_valid = 1'b0; in_value = '0; in_dots = '0; err_clr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_awvalid", 32'(awvalid), 32'd0);
        check("rst_wvalid", 32'(wvalid), 32'd0);
        check("rst_bready", 32'(bready), 32'd0);
        check("rst_awaddr", awaddr, 32'd0);
        check("rst_wdata", wdata, 32'd0);
        check("awprot", 32'(awprot), 32'd0);
        check("wstrb", 32'(wstrb), 32'hF);
        rstn = 1'b1;

        run_req(123,  3'b010, 12'h123, 1'b0, 1'b1, aw_hi, w_hi);
        run_req(0,    3'b000, 12'h000, 1'b0, 1'b1, aw_hi, w_hi);
        run_req(999,  3'b111, 12'h999, 1'b0, 1'b0, aw_hi, w_hi);
        run_req(1000, 3'b001, 12'hEEE, 1'b1, 1'b0, aw_hi, w_hi);
        run_req(45,   3'b100, 12'h045, 1'b0, 1'b0, aw_hi, w_hi);
        run_req(1023, 3'b000, 12'hEEE, 1'b1, 1'b0, aw_hi, w_hi);
        run_req(578,  3'b110, 12'h578, 1'b0, 1'b0, aw_hi, w_hi);

        // Address channel stalled 5 cycles on each write, data immediate.
        aw_stall = 5;
        run_req(321, 3'b011, 12'h321, 1'b0, 1'b1, aw_hi, w_hi);
        check("aw_valid_cycles", 32'(aw_hi), 32'd12);
        check("w_valid_cycles", 32'(w_hi), 32'd2);
        aw_stall = 0;

        // Data channel stalled, address immediate.
        w_stall = 3;
        run_req(60, 3'b001, 12'h060, 1'b0, 1'b0, aw_hi, w_hi);
        check("aw_valid_cycles_ws", 32'(aw_hi), 32'd2);
        check("w_valid_cycles_ws", 32'(w_hi), 32'd8);
        w_stall = 0;

        // Error on the digit write; the dot write must still happen.
        bresp_q.push_back(2'b10);
        run_req(7, 3'b101, 12'h007, 1'b0, 1'b0, aw_hi, w_hi);
        check("resp_err_set", 32'(resp_err), 32'd1);

        // err_clr coincides with an error on the dot response: error wins.
        bresp_q.push_back(2'b00);
        bresp_q.push_back(2'b11);
        fork
            run_req(88, 3'b001, 12'h088, 1'b0, 1'b0, aw_hi, w_hi);
            begin
                hit = 0;
                for (int c = 0; c < 400; c++) begin
                    @(negedge clk);
                    if (bvalid && bready && awaddr == BASE + 32'd4) begin hit = 1; break; end
                end
                if (!hit) check("b_dot_timeout", 32'd0, 32'd1);
                err_clr = 1'b1;
                @(negedge clk);
                err_clr = 1'b0;
                check("resp_err_priority", 32'(resp_err), 32'd1);
            end
        join
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("resp_err_clear", 32'(resp_err), 32'd0);

        // Reset while waiting for the digit write response.
        b_block = 1;
        exp_q.push_back({BASE, 32'h0000_0456});
        issue(456, 3'b110);
        hit = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (bready) begin hit = 1; break; end
        end
        check("reached_b_dig", 32'(hit), 32'd1);
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        check("abort_awvalid", 32'(awvalid), 32'd0);
        check("abort_wvalid", 32'(wvalid), 32'd0);
        check("abort_bready", 32'(bready), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_done", 32'(done), 32'd0);
        rstn = 1'b1;
        b_block = 0;
        run_req(456, 3'b110, 12'h456, 1'b0, 1'b1, aw_hi, w_hi);

        repeat (5) @(negedge clk);
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
